// File: rtl/acc_status_unit_if.sv
// Command/adder port bundle for acc_status_unit: sequencer strobe, bus operand,
// adder feedback and the registered accumulator/status outputs.
interface acc_status_unit_if #(
  parameter int WIDTH = 8
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             op_ready;
  logic             done;
  logic [WIDTH-1:0] acc_out;
  logic [WIDTH-1:0] opb_out;
  logic             cin_out;
  logic [3:0]       flags;

  modport master (
    output op_valid, op_code, bus_in, sum_in, cout_in,
    input  op_ready, done, acc_out, opb_out, cin_out, flags
  );

  modport slave (
    input  op_valid, op_code, bus_in, sum_in, cout_in,
    output op_ready, done, acc_out, opb_out, cin_out, flags
  );
endinterface

// File: rtl/acc_status_unit.sv
// Accumulator, operand latch and {V,N,Z,C} status around an external 8-bit adder.
// Optional feature: define ACC_OVERFLOW_FLAG_EN to implement the V flag (else flags[3]=0).
module acc_status_unit #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] ACC_RST = '0
) (
  input  logic               clk,
  input  logic               rst,
  acc_status_unit_if.slave   au
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDA = 3'b001,
    OP_ADD = 3'b010,
    OP_ADC = 3'b011,
    OP_SUB = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_CLR = 3'b111
  } op_t;

  state_t           state, state_next;
  logic             accept;

  op_t              op_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] acc;
  logic             c, z, n;
  logic             done, op_ready;

  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH-1:0] acc_nxt;
  logic             c_nxt, z_nxt, n_nxt;

  // Two's-complement overflow of a + b (+cin) from the operands the adder actually saw.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (au.op_valid && op_ready) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder operand decode from the latched command; combinational by design.
  always_comb begin
    opb = b_p0;
    if (state == EXEC && op_p0 == OP_SUB) opb = ~b_p0;
    cin = 1'b0;
    if (op_p0 == OP_ADC)      cin = c;
    else if (op_p0 == OP_SUB) cin = 1'b1;
  end

  always_comb begin
    acc_nxt = acc;
    c_nxt   = c;
    case (op_p0)
      OP_LDA: acc_nxt = b_p0;
      OP_ADD, OP_ADC, OP_SUB: begin
        acc_nxt = au.sum_in;
        c_nxt   = au.cout_in;
      end
      OP_SHL: begin
        acc_nxt = {acc[WIDTH-2:0], 1'b0};
        c_nxt   = acc[WIDTH-1];
      end
      OP_SHR: begin
        acc_nxt = {1'b0, acc[WIDTH-1:1]};
        c_nxt   = acc[0];
      end
      OP_CLR: begin
        acc_nxt = '0;
        c_nxt   = 1'b0;
      end
      default: ;
    endcase
    z_nxt = z;
    n_nxt = n;
    if (op_p0 != OP_NOP) begin
      z_nxt = (acc_nxt == '0);
      n_nxt = acc_nxt[WIDTH-1];
    end
  end

  // Stage p0: operand/command latch on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0 <= OP_NOP;
      b_p0  <= '0;
    end else if (accept) begin
      op_p0 <= op_t'(au.op_code);
      b_p0  <= au.bus_in;
    end
  end

  // Stage p1: writeback of ACC/status and retire handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= ACC_RST;
      c        <= 1'b0;
      z        <= 1'b0;
      n        <= 1'b0;
      done     <= 1'b0;
      op_ready <= 1'b1;
    end else begin
      done     <= (state == EXEC);
      op_ready <= (state_next == IDLE);
      if (state == EXEC) begin
        acc <= acc_nxt;
        c   <= c_nxt;
        z   <= z_nxt;
        n   <= n_nxt;
      end
    end
  end

`ifdef ACC_OVERFLOW_FLAG_EN
  logic v, v_nxt;

  always_comb begin
    v_nxt = v;
    case (op_p0)
      OP_ADD, OP_ADC, OP_SUB: v_nxt = add_ovf(acc, opb, au.sum_in);
      OP_CLR:                 v_nxt = 1'b0;
      default:                ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                v <= 1'b0;
    else if (state == EXEC) v <= v_nxt;
  end

  assign au.flags = {v, n, z, c};
`else
  assign au.flags = {1'b0, n, z, c};
`endif

  assign au.op_ready = op_ready;
  assign au.done     = done;
  assign au.acc_out  = acc;
  assign au.opb_out  = opb;
  assign au.cin_out  = cin;

endmodule

// File: tb/tb_acc_status_unit.sv
// Directed bench for acc_status_unit with a behavioural 8-bit adder on the feedback path.
module tb_acc_status_unit;

`ifdef ACC_OVERFLOW_FLAG_EN
  localparam logic VEN = 1'b1;
`else
  localparam logic VEN = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, ADD = 3'b010, ADC = 3'b011,
                         SUB = 3'b100, SHL = 3'b101, SHR = 3'b110, CLR = 3'b111;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  acc_status_unit_if #(.WIDTH(8)) intf ();

  acc_status_unit #(.WIDTH(8), .ACC_RST(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .au  (intf.slave)
  );

  // External adder model.
  assign {intf.cout_in, intf.sum_in} = {1'b0, intf.acc_out} + {1'b0, intf.opb_out}
                                       + {8'h00, intf.cin_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] fl(input logic v, input logic n, input logic z, input logic c);
    return {v & VEN, n, z, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_op(input string tag, input logic [2:0] code, input logic [7:0] b,
                       input logic [7:0] exp_opb, input logic exp_cin,
                       input logic [7:0] exp_acc, input logic [3:0] exp_flags);
    chk({tag, "_ready_pre"}, intf.op_ready, 1);
    intf.op_valid = 1'b1;
    intf.op_code  = code;
    intf.bus_in   = b;
    @(posedge clk); #1;
    intf.op_valid = 1'b0;
    intf.op_code  = NOP;
    intf.bus_in   = 8'hA5;
    chk({tag, "_exec_ready"}, intf.op_ready, 0);
    chk({tag, "_exec_done"}, intf.done, 0);
    chk({tag, "_opb"}, intf.opb_out, exp_opb);
    chk({tag, "_cin"}, intf.cin_out, exp_cin);
    @(posedge clk); #1;
    chk({tag, "_done"}, intf.done, 1);
    chk({tag, "_ready"}, intf.op_ready, 1);
    chk({tag, "_acc"}, intf.acc_out, exp_acc);
    chk({tag, "_flags"}, intf.flags, exp_flags);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    intf.op_valid = 1'b0;
    intf.op_code  = NOP;
    intf.bus_in   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", intf.acc_out, 8'h00);
    chk("rst_flags", intf.flags, 4'h0);
    chk("rst_ready", intf.op_ready, 1);
    chk("rst_done", intf.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of an ADD aborts it.
    do_op("lda10", LDA, 8'h10, 8'h10, 1'b0, 8'h10, fl(0, 0, 0, 0));
    intf.op_valid = 1'b1;
    intf.op_code  = ADD;
    intf.bus_in   = 8'h22;
    @(posedge clk); #1;
    intf.op_valid = 1'b0;
    chk("abort_exec_ready", intf.op_ready, 0);
    rst = 1'b1;
    #2;
    chk("abort_acc", intf.acc_out, 8'h00);
    chk("abort_flags", intf.flags, 4'h0);
    chk("abort_ready", intf.op_ready, 1);
    chk("abort_done", intf.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_done_after", intf.done, 0);
    chk("abort_acc_after", intf.acc_out, 8'h00);

    // Signed overflow into bit 7.
    do_op("lda7f", LDA, 8'h7F, 8'h7F, 1'b0, 8'h7F, fl(0, 0, 0, 0));
    do_op("add01", ADD, 8'h01, 8'h01, 1'b0, 8'h80, fl(1, 1, 0, 0));

    // Carry out then carry in.
    do_op("ldaff", LDA, 8'hFF, 8'hFF, 1'b0, 8'hFF, fl(1, 1, 0, 0));
    do_op("addff", ADD, 8'h01, 8'h01, 1'b0, 8'h00, fl(0, 0, 1, 1));
    do_op("adc00", ADC, 8'h00, 8'h00, 1'b1, 8'h01, fl(0, 0, 0, 0));

    // Subtract: no borrow then borrow.
    do_op("lda05", LDA, 8'h05, 8'h05, 1'b0, 8'h05, fl(0, 0, 0, 0));
    do_op("sub05", SUB, 8'h05, 8'hFA, 1'b1, 8'h00, fl(0, 0, 1, 1));
    do_op("sub01", SUB, 8'h01, 8'hFE, 1'b1, 8'hFF, fl(0, 1, 0, 0));

    // Shifts, clear, nop.
    do_op("lda81", LDA, 8'h81, 8'h81, 1'b0, 8'h81, fl(0, 1, 0, 0));
    do_op("shl", SHL, 8'h00, 8'h00, 1'b0, 8'h02, fl(0, 0, 0, 1));
    do_op("shr", SHR, 8'h00, 8'h00, 1'b0, 8'h01, fl(0, 0, 0, 0));
    do_op("lda7f_b", LDA, 8'h7F, 8'h7F, 1'b0, 8'h7F, fl(0, 0, 0, 0));
    do_op("add01_b", ADD, 8'h01, 8'h01, 1'b0, 8'h80, fl(1, 1, 0, 0));
    do_op("clr", CLR, 8'h00, 8'h00, 1'b0, 8'h00, fl(0, 0, 1, 0));
    do_op("nop", NOP, 8'h33, 8'h33, 1'b0, 8'h00, fl(0, 0, 1, 0));

    // op_valid held high: accepts every other cycle, second ADD sees the first result.
    do_op("lda10_b", LDA, 8'h10, 8'h10, 1'b0, 8'h10, fl(0, 0, 0, 0));
    intf.op_valid = 1'b1;
    intf.op_code  = ADD;
    intf.bus_in   = 8'h03;
    @(posedge clk); #1;
    chk("b2b_exec1_ready", intf.op_ready, 0);
    chk("b2b_exec1_done", intf.done, 0);
    @(posedge clk); #1;
    chk("b2b_ret1_done", intf.done, 1);
    chk("b2b_ret1_ready", intf.op_ready, 1);
    chk("b2b_ret1_acc", intf.acc_out, 8'h13);
    @(posedge clk); #1;
    intf.op_valid = 1'b0;
    chk("b2b_exec2_ready", intf.op_ready, 0);
    chk("b2b_exec2_done", intf.done, 0);
    chk("b2b_exec2_acc", intf.acc_out, 8'h13);
    @(posedge clk); #1;
    chk("b2b_ret2_done", intf.done, 1);
    chk("b2b_ret2_acc", intf.acc_out, 8'h16);
    chk("b2b_ret2_flags", intf.flags, fl(0, 0, 0, 0));
    @(posedge clk); #1;
    chk("b2b_done_pulse", intf.done, 0);
    chk("b2b_idle_acc", intf.acc_out, 8'h16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
